seq_mult16: RTL and testbench
=============================

Name: seq_mult16

Overview:
- Sequential 16x16 shift-add multiplier built around the team's 16-bit carry-lookahead adder (sixteen_bit_full_adder). The multiplier is the stage that feeds that adder and consumes its Sum/Cout.
- Takes operands over a valid/ready handshake and iterates one partial-product add per clock.
- Returns a 32-bit product plus zero and 16-bit-overflow flags over a second valid/ready handshake.
- Sits between the operand register file and the ALU result mux.

Parameters:
- W, 16, operand width; only 16 supported (fixed by the adder); 32-bit product.
- CNT_W, 4, iteration counter width (log2 W).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  16  multiplicand
- b  input  16  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- prod  output  32  product
- zf  output  1  prod == 0
- ovf16  output  1  product does not fit in 16 bits
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - prod=0, zf=0, ovf16=0; all internal registers (A, HI, Q, cnt, sign) = 0.
- Internal registers:
  - A[15:0]: multiplicand.
  - HI[15:0]: upper accumulator.
  - Q[15:0]: multiplier, shifted right as it iterates; low half of the product.
  - cnt[CNT_W-1:0]: iteration counter.
- Adder hookup:
  - One adder instance: Num_1=HI, Num_2=Q[0] ? A : 16'h0, Cin=0.
  - Adder flag outputs are unused except Cout.
- States: IDLE, RUN, DONE (plus NEG when SEQ_MULT_SIGNED_EN is defined).
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: A<=a, Q<=b, HI<=0, cnt<=0, go to RUN.
  - a/b are ignored at all other times.
- RUN (one iteration per clock):
  - {HI,Q} <= {Cout, Sum, Q[15:1]}; cnt<=cnt+1.
  - When cnt==15, perform the update and go to DONE.
  - Exactly 16 RUN cycles.
- DONE:
  - out_valid=1, prod={HI,Q}, zf=(prod==0).
  - ovf16: unsigned = |prod[31:16]; signed = prod[31:15] not all-equal.
  - prod, zf and ovf16 stay stable while out_valid && !out_ready.
  - On out_ready: go to IDLE.
  - out_valid drops the next cycle; prod/flags hold their last value until the next DONE.
- Latency: out_valid rises 16 clocks after the accepting edge (17 with the signed option).
- Throughput: one op per 18 cycles minimum. No overlap: in_ready=0 in RUN, DONE and NEG, including the cycle out_ready is sampled.
- Simultaneous events:
  - in_valid during DONE is ignored; the source must hold it until in_ready.
  - out_ready outside DONE has no effect.
- Reset mid-operation: an immediate asynchronous return to IDLE with reset values. The partial result is discarded and no out_valid is produced.
- Arithmetic: unsigned 16x16 -> 32, exact; the carry out of each add is captured via Cout, never lost.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined: operands are two's complement.
  - At accept: A<=|a|, Q<=|b| (0x8000 maps to magnitude 0x8000 unsigned) and sign<=a[15]^b[15].
  - After RUN, a one-cycle NEG state sets {HI,Q} <= sign ? -{HI,Q} : {HI,Q} (32-bit two's complement negate), then goes to DONE.
  - Latency is 17.
  - ovf16 uses the signed rule.
- Undefined: unsigned operation, no NEG state, no sign register, latency 16, unsigned ovf16 rule.

Test Plan:
- Reset, then a=3, b=5, in_valid for one cycle, out_ready=1 -> out_valid exactly 16 cycles after accept; prod=0x0000000F, zf=0, ovf16=0; in_ready returns to 1 the cycle after the handshake.
- a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001, ovf16=1; a=0x0000, b=0x1234 -> prod=0, zf=1.
- Hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and a=7, b=9 asserted -> prod holds 0xFFFE0001, in_ready stays 0; after out_ready pulses, the 7x9 op is accepted and yields prod=63.
- Assert rst_n=0 for 1 cycle at RUN iteration 8 of 0x1234*0x5678 -> all outputs 0, state IDLE, no out_valid; then 0x1234*0x5678 -> prod=0x06260060.
- Back-to-back ops with in_valid and out_ready held high -> one product every 18 cycles; products match the golden model for 1000 random pairs.
- With SEQ_MULT_SIGNED_EN:
  - a=0xFFFD (-3), b=5 -> prod=0xFFFFFFF1, latency 17, ovf16=0.
  - a=0x8000, b=0x8000 -> prod=0x40000000, ovf16=1.
  - a=0xFFFF, b=0xFFFF -> prod=1.

Source files
------------

// File: rtl/seq_mult16.sv
// seq_mult16: sequential 16x16 shift-add multiplier, one partial-product add per clock.
// Operands arrive on an in_valid/in_ready handshake; the 32-bit product with zero and
// 16-bit-overflow flags leaves on an out_valid/out_ready handshake.
// Optional build macro SEQ_MULT_SIGNED_EN: two's complement operands (adds a NEG state).

// 16-bit carry-lookahead adder: 4-bit groups with a second lookahead level across groups.
module sixteen_bit_full_adder (
    input  logic [15:0] Num_1,
    input  logic [15:0] Num_2,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;

    assign g = Num_1 & Num_2;
    assign p = Num_1 ^ Num_2;

    // Group generate/propagate, group carries, then bit carries inside each group.
    always_comb begin
        gg    = '0;
        gp    = '0;
        cg    = '0;
        c     = '0;
        cg[0] = Cin;
        for (int k = 0; k < 4; k++) begin
            gp[k]   = &p[4*k +: 4];
            gg[k]   = g[4*k+3]
                    | (p[4*k+3] & g[4*k+2])
                    | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                    | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
        c[0] = Cin;
        for (int i = 0; i < 16; i++) begin
            c[i+1] = ((i % 4) == 3) ? cg[i/4 + 1] : (g[i] | (p[i] & c[i]));
        end
    end

    assign Sum  = p ^ c[15:0];
    assign Cout = c[16];
endmodule

module seq_mult16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] prod,
    output logic        zf,
    output logic        ovf16,
    output logic        busy
);
    localparam int unsigned W     = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_NEG  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [W-1:0]       a_q, a_nxt;
    logic [W-1:0]       hi_q, hi_nxt;
    logic [W-1:0]       q_q, q_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [2*W-1:0]     prod_nxt;
    logic               zf_nxt;
    logic               ovf_nxt;
    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic               busy_nxt;
    logic [W-1:0]       add_sum;
    logic               add_cout;
`ifdef SEQ_MULT_SIGNED_EN
    logic               sign_q, sign_nxt;
`endif

    // Single adder: accumulate the multiplicand when the current multiplier bit is set.
    sixteen_bit_full_adder u_add (
        .Num_1 (hi_q),
        .Num_2 (q_q[0] ? a_q : W'(0)),
        .Cin   (1'b0),
        .Sum   (add_sum),
        .Cout  (add_cout)
    );

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            hi_q      <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            prod      <= '0;
            zf        <= 1'b0;
            ovf16     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            a_q       <= a_nxt;
            hi_q      <= hi_nxt;
            q_q       <= q_nxt;
            cnt_q     <= cnt_nxt;
            prod      <= prod_nxt;
            zf        <= zf_nxt;
            ovf16     <= ovf_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q    <= sign_nxt;
`endif
        end
    end

    // Next state and datapath updates: load, 16 shift-add iterations, optional negate.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        hi_nxt    = hi_q;
        q_nxt     = q_q;
        cnt_nxt   = cnt_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_nxt  = sign_q;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SEQ_MULT_SIGNED_EN
                    a_nxt    = a[W-1] ? W'(~a + W'(1)) : a;
                    q_nxt    = b[W-1] ? W'(~b + W'(1)) : b;
                    sign_nxt = a[W-1] ^ b[W-1];
`else
                    a_nxt    = a;
                    q_nxt    = b;
`endif
                    hi_nxt    = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                {hi_nxt, q_nxt} = {add_cout, add_sum, q_q[W-1:1]};
                cnt_nxt         = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                    state_nxt = S_NEG;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_NEG: begin
`ifdef SEQ_MULT_SIGNED_EN
                if (sign_q) begin
                    {hi_nxt, q_nxt} = (2*W)'(~{hi_q, q_q} + (2*W)'(1));
                end
                state_nxt = S_DONE;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; result and flags latch on entry to DONE.
    always_comb begin
        in_ready_nxt  = (state_nxt == S_IDLE);
        busy_nxt      = (state_nxt != S_IDLE);
        out_valid_nxt = (state_nxt == S_DONE);
        prod_nxt      = prod;
        zf_nxt        = zf;
        ovf_nxt       = ovf16;
        if ((state_nxt == S_DONE) && (state != S_DONE)) begin
            prod_nxt = {hi_nxt, q_nxt};
            zf_nxt   = ({hi_nxt, q_nxt} == (2*W)'(0));
`ifdef SEQ_MULT_SIGNED_EN
            ovf_nxt  = !((&hi_nxt && q_nxt[W-1]) || (~|hi_nxt && !q_nxt[W-1]));
`else
            ovf_nxt  = |hi_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: randomized and directed checks of seq_mult16 against an arithmetic model.
// Honors SEQ_MULT_SIGNED_EN the same way as the design.
module tb_seq_mult16;
`ifdef SEQ_MULT_SIGNED_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif
    localparam int INTERVAL = LAT + 2;
    localparam int N_RAND   = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod;
    logic        zf;
    logic        ovf16;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    seq_mult16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .zf        (zf),
        .ovf16     (ovf16),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_prod(input logic [15:0] x, input logic [15:0] y);
        longint r;
`ifdef SEQ_MULT_SIGNED_EN
        r = longint'($signed(x)) * longint'($signed(y));
`else
        r = longint'({48'd0, x}) * longint'({48'd0, y});
`endif
        return r[31:0];
    endfunction

    function automatic logic model_ovf(input logic [31:0] p);
`ifdef SEQ_MULT_SIGNED_EN
        int sp;
        sp = $signed(p);
        return (sp > 32767) || (sp < -32768);
`else
        return p > 32'h0000_FFFF;
`endif
    endfunction

    // Issue one operation from a negedge; returns result observed when out_valid is first seen.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ordy,
                          output logic [31:0] p, output logic z, output logic o, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        out_ready = ordy;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        p = prod;
        z = zf;
        o = ovf16;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        n_chk++;
        if ({in_ready, out_valid, busy, prod, zf, ovf16} !== {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b busy=%b prod=%h zf=%b ovf=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, prod, zf, ovf16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] p;
        logic        z, o;
        int          lat;
        run_op(16'd3, 16'd5, 1'b1, p, z, o, lat);
        n_chk++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        end
        n_chk++;
        if (p !== 32'h0000_000F || z !== 1'b0 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_3x5: got prod=%h zf=%b ovf=%b want 0000000f 0 0", p, z, o);
        end
        n_chk++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_ready: got rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return_idle: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_ovf_zero();
        logic [31:0] p;
        logic        z, o;
        int          lat;
        run_op(16'hFFFF, 16'hFFFF, 1'b1, p, z, o, lat);
        n_chk++;
`ifdef SEQ_MULT_SIGNED_EN
        if (p !== 32'h0000_0001 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL ffff_x_ffff: got prod=%h ovf=%b want 00000001 0", p, o);
        end
`else
        if (p !== 32'hFFFE_0001 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL ffff_x_ffff: got prod=%h ovf=%b want fffe0001 1", p, o);
        end
`endif
        @(negedge clk);
        run_op(16'h0000, 16'h1234, 1'b1, p, z, o, lat);
        n_chk++;
        if (p !== 32'd0 || z !== 1'b1 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_x_1234: got prod=%h zf=%b ovf=%b want 0 1 0", p, z, o);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [31:0] p, exp_p;
        logic        z, o;
        int          lat;
        exp_p = model_prod(16'hFFFF, 16'hFFFF);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, p, z, o, lat);
        in_valid = 1'b1;
        a        = 16'd7;
        b        = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || prod !== exp_p || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vld=%b prod=%h rdy=%b want 1 %h 0",
                         i, out_valid, prod, in_ready, exp_p);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod !== exp_p) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b vld=%b prod=%h want 1 0 %h", in_ready, out_valid, prod, exp_p);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        a         = 16'hAAAA;
        b         = 16'h5555;
        out_ready = 1'b1;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (prod !== 32'd63 || lat !== LAT) begin
            n_fail++;
            $display("FAIL hold_7x9: got prod=%0d lat=%0d want 63 %0d", prod, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] p;
        logic        z, o;
        int          lat;
        bit          seen;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h5678;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, out_valid, busy, prod, zf, ovf16} !== {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b prod=%h zf=%b ovf=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, prod, zf, ovf16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_output: got activity=%b want 0", seen);
        end
        run_op(16'h1234, 16'h5678, 1'b1, p, z, o, lat);
        n_chk++;
        if (p !== 32'h0626_0060 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_op: got prod=%h ovf=%b want 06260060 1", p, o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] ep;
        int          issued, received, cyc, last_cyc;
        issued    = 0;
        received  = 0;
        cyc       = 0;
        last_cyc  = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (received < N_RAND && cyc < N_RAND * (INTERVAL + 4) + 100) begin
            if (out_valid) begin
                ep = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_chk++;
                if (prod !== ep || zf !== (ep == 32'd0) || ovf16 !== model_ovf(ep)) begin
                    n_fail++;
                    $display("FAIL b2b_op%0d: got prod=%h zf=%b ovf=%b want %h %b %b",
                             received, prod, zf, ovf16, ep, (ep == 32'd0), model_ovf(ep));
                end
                if (last_cyc >= 0) begin
                    n_chk++;
                    if (cyc - last_cyc !== INTERVAL) begin
                        n_fail++;
                        $display("FAIL b2b_interval%0d: got %0d want %0d", received, cyc - last_cyc, INTERVAL);
                    end
                end
                last_cyc = cyc;
                received++;
            end
            if (in_ready) begin
                if (issued < N_RAND) begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                    exp_q.push_back(model_prod(a, b));
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_chk++;
        if (received !== N_RAND) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d products want %0d", received, N_RAND);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        logic [31:0] p;
        logic        z, o;
        int          lat;
        run_op(16'hFFFD, 16'd5, 1'b1, p, z, o, lat);
        n_chk++;
        if (p !== 32'hFFFF_FFF1 || o !== 1'b0 || lat !== 17) begin
            n_fail++;
            $display("FAIL signed_m3x5: got prod=%h ovf=%b lat=%0d want fffffff1 0 17", p, o, lat);
        end
        @(negedge clk);
        run_op(16'h8000, 16'h8000, 1'b1, p, z, o, lat);
        n_chk++;
        if (p !== 32'h4000_0000 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_min_sq: got prod=%h ovf=%b want 40000000 1", p, o);
        end
        @(negedge clk);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, p, z, o, lat);
        n_chk++;
        if (p !== 32'd1 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL signed_m1xm1: got prod=%h ovf=%b want 00000001 0", p, o);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ovf_zero();
        test_hold();
        test_reset_mid();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
